// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - eight-digit seven-segment scan controller with frame-aligned updates
//
// Steps through the eight hex nibbles of a committed 32-bit value, holding each
// digit REFRESH_DIV clocks, and presents the current digit to the downstream
// seven-segment decoder. Writes are parked in a shadow register and only reach
// the displayed value when the scan wraps from digit 7 to digit 0, so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   wr_en        one-cycle write strobe for wr_data
//   wr_data      nibble i is the value for digit i
//   digit_en     bit i = 0 forces digit i dark
//   blank_lz     1 = blank leading zeros (digit 0 always shown)
//   num          nibble of the current digit
//   sel          index of the current digit
//   blank        1 = current digit must be dark
//   upd_pending  a write is waiting for the next frame boundary
//   frame_done   one-cycle pulse in the first cycle of a new frame

module display_scanner #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   output logic [3:0]  num,
   output logic [2:0]  sel,
   output logic        blank,
   output logic        upd_pending,
   output logic        frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [31:0]   disp;
   logic [31:0]   shadow;
   logic [31:0]   disp_n;
   logic [2:0]    sel_n;
   logic          tick;
   logic          wrap;
   logic          lz_blank;
   logic          running;
   logic [7:0]    upper_zero;

   always_comb begin
      tick  = (cnt == CNT_MAX);
      wrap  = tick && (sel == 3'd7);
      sel_n = tick ? sel + 3'd1 : sel;

      // A write landing exactly on the wrap is newer than anything in shadow.
      disp_n = disp;
      if (wrap) begin
         if (wr_en)
            disp_n = wr_data;
         else if (upd_pending)
            disp_n = shadow;
      end

      // upper_zero[i]: nibbles 7 down to i of the next displayed value are all zero.
      upper_zero = '0;
      running    = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         running       = running && (disp_n[4*i +: 4] == 4'd0);
         upper_zero[i] = running;
      end

      lz_blank = blank_lz && (sel_n != 3'd0) && upper_zero[sel_n];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         sel         <= '0;
         disp        <= '0;
         shadow      <= '0;
         upd_pending <= 1'b0;
         num         <= '0;
         blank       <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         cnt  <= tick ? '0 : cnt + CW'(1);
         sel  <= sel_n;
         disp <= disp_n;

         if (wr_en && !wrap)
            shadow <= wr_data;

         if (wrap)
            upd_pending <= 1'b0;
         else if (wr_en)
            upd_pending <= 1'b1;

         // Driven from next-state sel/disp so data and select move on the same edge.
         num        <= disp_n[{sel_n, 2'b00} +: 4];
         blank      <= ~digit_en[sel_n] | lz_blank;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - self-checking bench for display_scanner

module tb_display_scanner;

   localparam int R   = 4;
   localparam int PER = 8 * R;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic [7:0]  digit_en = 8'hFF;
   logic        blank_lz = 1'b0;
   logic [3:0]  num;
   logic [2:0]  sel;
   logic        blank;
   logic        upd_pending;
   logic        frame_done;

   int checks = 0;
   int failures = 0;

   // Reference model: time since reset drives the scan position arithmetically.
   int          m_t = 0;
   int          m_sel = 0;
   logic [31:0] m_disp = '0;
   logic [31:0] m_shadow = '0;
   logic        m_pend = 1'b0;
   logic        m_fd = 1'b0;
   logic [3:0]  m_num = '0;
   logic        m_blank = 1'b0;

   display_scanner #(.REFRESH_DIV(R)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .digit_en(digit_en), .blank_lz(blank_lz), .num(num), .sel(sel),
      .blank(blank), .upd_pending(upd_pending), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      logic [31:0] upper;
      if (rst) begin
         m_t = 0; m_sel = 0; m_disp = '0; m_shadow = '0;
         m_pend = 1'b0; m_fd = 1'b0; m_num = '0; m_blank = 1'b0;
      end else begin
         m_fd = ((m_t % PER) == PER - 1);
         if (m_fd) begin
            if (wr_en) m_disp = wr_data;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 1'b0;
         end else if (wr_en) begin
            m_shadow = wr_data;
            m_pend = 1'b1;
         end
         m_t++;
         m_sel   = (m_t / R) % 8;
         upper   = m_disp >> (4 * m_sel);
         m_num   = upper[3:0];
         m_blank = !digit_en[m_sel] || (blank_lz && m_sel != 0 && upper == 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   // Advances until the next clock edge is the 7 -> 0 wrap.
   task automatic goto_wrap_edge();
      for (int n = 0; n < 3 * PER && (m_t % PER) != PER - 1; n++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      checks++; if (num !== 4'd0) begin failures++; $display("FAIL reset_num got=%0h exp=0", num); end
      checks++; if (blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", blank); end
      checks++; if (upd_pending !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", upd_pending); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (sel !== ((k == 4) ? 3'd1 : 3'd0)) begin
            failures++; $display("FAIL reset_first_tick cyc=%0d got=%0d exp=%0d", k, sel, (k == 4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_deferred();
      logic [31:0] val;
      val = 32'h89ABCDEF;
      for (int n = 0; n < 3 * PER && m_sel != 3; n++) step();
      checks++; if (sel !== 3'd3) begin failures++; $display("FAIL defer_start_sel got=%0d exp=3", sel); end
      wr_en = 1'b1; wr_data = val;
      step();
      wr_en = 1'b0;
      checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL defer_pend_rise got=%b exp=1", upd_pending); end
      for (int n = 0; n < 2 * PER; n++) begin
         step();
         if (m_fd) break;
         checks++;
         if (num !== 4'd0 || upd_pending !== 1'b1) begin
            failures++; $display("FAIL defer_hold sel=%0d num=%0h pend=%b exp num=0 pend=1", sel, num, upd_pending);
         end
      end
      checks++;
      if (sel !== 3'd0 || num !== 4'hF || frame_done !== 1'b1 || upd_pending !== 1'b0) begin
         failures++;
         $display("FAIL defer_commit sel=%0d num=%0h fd=%b pend=%b exp 0 F 1 0", sel, num, frame_done, upd_pending);
      end
      for (int k = 1; k < PER; k++) begin
         step();
         checks++;
         if (sel !== 3'(k / R) || num !== val[4*(k/R) +: 4] || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL defer_digits k=%0d sel=%0d num=%0h fd=%b exp sel=%0d num=%0h fd=0",
                     k, sel, num, frame_done, k / R, val[4*(k/R) +: 4]);
         end
      end
   endtask

   task automatic test_wrap_write();
      goto_wrap_edge();
      checks++; if (sel !== 3'd7) begin failures++; $display("FAIL wrapw_pre_sel got=%0d exp=7", sel); end
      wr_en = 1'b1; wr_data = 32'h00000001;
      step();
      wr_en = 1'b0;
      checks++;
      if (sel !== 3'd0 || num !== 4'd1 || upd_pending !== 1'b0) begin
         failures++; $display("FAIL wrapw_commit sel=%0d num=%0h pend=%b exp 0 1 0", sel, num, upd_pending);
      end
      repeat (3) step();
      wr_en = 1'b1; wr_data = 32'h11111111; step(); wr_en = 1'b0;
      repeat (5) step();
      wr_en = 1'b1; wr_data = 32'h22222222; step(); wr_en = 1'b0;
      checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL wrapw_pend got=%b exp=1", upd_pending); end
      goto_wrap_edge();
      for (int k = 0; k < PER; k++) begin
         step();
         checks++;
         if (num !== 4'd2 || upd_pending !== 1'b0) begin
            failures++; $display("FAIL wrapw_last_wins k=%0d num=%0h pend=%b exp num=2 pend=0", k, num, upd_pending);
         end
      end
   endtask

   task automatic test_lz();
      logic [31:0] val;
      val = 32'h00000305;
      blank_lz = 1'b1;
      goto_wrap_edge();
      wr_en = 1'b1; wr_data = val; step(); wr_en = 1'b0;
      for (int k = 0; k < PER; k++) begin
         checks++;
         if (num !== val[4*(k/R) +: 4] || blank !== ((k / R) >= 3)) begin
            failures++;
            $display("FAIL lz_blank k=%0d sel=%0d num=%0h blank=%b exp num=%0h blank=%b",
                     k, sel, num, blank, val[4*(k/R) +: 4], (k / R) >= 3);
         end
         step();
      end
      for (int n = 0; n < 3 * PER && m_sel != 5; n++) step();
      checks++; if (blank !== 1'b1) begin failures++; $display("FAIL lz_pre_off got=%b exp=1", blank); end
      blank_lz = 1'b0;
      for (int k = 0; k < PER; k++) begin
         step();
         checks++;
         if (blank !== 1'b0) begin failures++; $display("FAIL lz_off k=%0d sel=%0d got=%b exp=0", k, sel, blank); end
      end
      blank_lz = 1'b1;
      goto_wrap_edge();
      wr_en = 1'b1; wr_data = 32'h0; step(); wr_en = 1'b0;
      for (int k = 0; k < PER; k++) begin
         checks++;
         if (num !== 4'd0 || blank !== ((k / R) != 0)) begin
            failures++; $display("FAIL lz_zero k=%0d num=%0h blank=%b exp num=0 blank=%b", k, num, blank, (k / R) != 0);
         end
         step();
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_enable();
      digit_en = 8'b0000_1111;
      goto_wrap_edge();
      for (int k = 0; k < PER; k++) begin
         step();
         checks++;
         if (blank !== ((k / R) >= 4)) begin
            failures++; $display("FAIL enable_mask k=%0d sel=%0d got=%b exp=%b", k, sel, blank, (k / R) >= 4);
         end
      end
      digit_en = 8'hFF;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_data = $urandom;
         if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 3) == 0) wr_data[31:16] = '0;
         step();
         checks++;
         if (sel !== 3'(m_sel) || num !== m_num || blank !== m_blank ||
             upd_pending !== m_pend || frame_done !== m_fd) begin
            failures++;
            $display("FAIL random k=%0d got sel=%0d num=%0h blank=%b pend=%b fd=%b exp %0d %0h %b %b %b",
                     k, sel, num, blank, upd_pending, frame_done, m_sel, m_num, m_blank, m_pend, m_fd);
         end
      end
      wr_en = 1'b0; digit_en = 8'hFF; blank_lz = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 3 * PER && m_sel != 5; n++) step();
      wr_en = 1'b1; wr_data = $urandom | 32'h1; step(); wr_en = 1'b0;
      checks++; if (upd_pending !== 1'b1) begin failures++; $display("FAIL rstmid_pend got=%b exp=1", upd_pending); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++;
      if (sel !== 3'd0 || num !== 4'd0 || upd_pending !== 1'b0 || frame_done !== 1'b0) begin
         failures++; $display("FAIL rstmid_state sel=%0d num=%0h pend=%b fd=%b exp 0 0 0 0", sel, num, upd_pending, frame_done);
      end
      for (int k = 0; k < PER + 8; k++) begin
         step();
         checks++;
         if (num !== 4'd0 || upd_pending !== 1'b0) begin
            failures++; $display("FAIL rstmid_dropped k=%0d num=%0h pend=%b exp num=0 pend=0", k, num, upd_pending);
         end
      end
   endtask

   initial begin
      test_reset();
      test_deferred();
      test_wrap_write();
      test_lz();
      test_enable();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexing scan controller for the 8-digit seven-segment display. Holds a 32-bit value (eight hex nibbles), steps through the digits at a programmable refresh rate, and presents one digit at a time as `num` and `sel` to the seven-segment decoder directly downstream. Adds per-digit enable masking, optional leading-zero blanking, and tear-free updates: new values commit only at frame boundaries.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is held (100 MHz gives 1 kHz per digit, 125 Hz frame); legal range ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: one-cycle strobe; captures `wr_data`.
- `wr_data` input 32: nibble i (bits 4i+3:4i) is the value for digit i.
- `digit_en` input 8: bit i = 1 enables digit i; 0 forces it blank.
- `blank_lz` input 1: 1 enables leading-zero blanking.
- `num` output 4: nibble of the current digit, to the decoder.
- `sel` output 3: current digit index, to the decoder.
- `blank` output 1: 1 = current digit must be dark; the top level gates the anodes with it.
- `upd_pending` output 1: a write is waiting for the next frame boundary.
- `frame_done` output 1: one-cycle pulse when the scan wraps from 7 to 0.

## Operation
- Registers:
  - `cnt` is the prescaler, 0..REFRESH_DIV-1, using $clog2(REFRESH_DIV) bits.
  - `sel` is 3 bits and wraps naturally.
  - `disp` is the 32-bit committed value.
  - `shadow` is the 32-bit pending value.
  - `upd_pending`, `num`, `blank` and `frame_done` are registered outputs.
- Tick: asserted when `cnt == REFRESH_DIV-1`. On a tick, `cnt` goes to 0 and `sel` goes to `sel+1` mod 8. Otherwise `cnt` increments.
- Wrap: a tick while `sel == 7`.
- Write while not at a wrap:
  - `shadow` is loaded with `wr_data` and `upd_pending` is set to 1.
  - A later write in the same frame overwrites `shadow`; the last write wins.
- Commit at a wrap:
  - If `wr_en` is high, `disp` is loaded directly from `wr_data` (the write wins over any older `shadow`).
  - Else, if `upd_pending` is 1, `disp` is loaded from `shadow`.
  - In both cases `upd_pending` is cleared.
- `num`/`blank` register: each cycle, load from the next-state `sel` (sel_n) and next-state `disp` (disp_n).
  - `num` is nibble sel_n of disp_n.
  - `blank` = `~digit_en[sel_n]` OR (`blank_lz` AND sel_n ≠ 0 AND nibbles 7..sel_n of disp_n are all zero).
- Digit 0 is never blanked by leading-zero logic, so the value zero shows a single "0".
- `frame_done` register: 1 in the cycle after a wrap, 0 otherwise.

## Timing
- Reset (synchronous, dominates all other inputs): `cnt`=0, `sel`=0, `disp`=0, `shadow`=0, `upd_pending`=0, `num`=0, `blank`=0, `frame_done`=0.
- Reset mid-frame drops any pending write.
- `num`, `blank` and `sel` change on the same clock edge. There is no skew between `sel` and its data.
- Each digit is held exactly REFRESH_DIV cycles; a full frame is 8×REFRESH_DIV cycles.
- The first tick after reset occurs REFRESH_DIV cycles after `rst` deasserts.
- Changes on `digit_en` or `blank_lz` appear on `blank` one cycle later, without waiting for a tick.
- Write-to-display latency:
  - Minimum 1 cycle, when the write coincides with a wrap.
  - Maximum 8×REFRESH_DIV cycles.
- `upd_pending` rises the cycle after a non-wrap write and falls the cycle after the wrap.
- `frame_done` is high in the same cycle that `sel` first reads 0 of the new frame.

## Test plan
All scenarios use REFRESH_DIV=4, `digit_en`=8'hFF, `blank_lz`=0 unless stated.

- Reset: hold `rst` 3 cycles, release → `sel`=0, `num`=0, `blank`=0, `upd_pending`=0, `frame_done`=0; `sel` reads 1 exactly 4 cycles later.
- Deferred commit: write 32'h89ABCDEF while `sel`=3 → `upd_pending`=1 and `num` stays 0 through `sel` 3..7. At the wrap: `sel`=0, `num`=F, `frame_done`=1 for 1 cycle, `upd_pending`=0. Subsequent digits are E, D, C, B, A, 9, 8, each held 4 cycles.
- Write coincident with wrap (`wr_en` on the tick with `sel`=7): commit 32'h00000001 → next cycle `sel`=0, `num`=1, `upd_pending` stays 0. Also: two writes in one frame (32'h11111111, then 32'h22222222) → after the wrap all digits show 2.
- Leading-zero blanking: commit 32'h00000305 with `blank_lz`=1:
  - `blank`=1 at `sel` 3..7.
  - `sel`=2 gives `num`=3, `blank`=0; `sel`=1 gives `num`=0, `blank`=0.
  - Then `blank_lz`=0 → `blank`=0 for all digits, starting 1 cycle later.
  - With value 0 and `blank_lz`=1: only `sel`=0 is unblanked.
- Enable mask: `digit_en`=8'b0000_1111 → `blank`=1 at `sel` 4..7 and 0 at `sel` 0..3.
- Reset mid-operation: `rst` at `sel`=5 with a pending write → next cycle `sel`=0, `num`=0, `upd_pending`=0; the pending value is never displayed.
